writeback_regfile: RTL and testbench

- Writeback stage of the sequential Y86-64 core. Sits directly downstream of the memory stage.
- Consumes icode, cnd, rA, rB, valE, valM and the memory error flag.
- Derives the E-port and M-port destination registers and writes the 15-entry register file on the clock edge.
- Holds the sticky processor status and a retired-instruction counter. Provides combinational read ports for the decode stage.

---
 rtl/writeback_regfile_pkg.sv | 42 ++++
 rtl/regfile_2r2w.sv | 50 +++++
 rtl/writeback_regfile.sv | 118 +++++++++++
 tb/tb_writeback_regfile.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared Y86-64 constants for the writeback stage.
// Instruction codes, register IDs and status codes.
package writeback_regfile_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic {
    ST_RUN,
    ST_STOP
  } wb_state_e;

  function automatic logic [2:0] instr_stat(
    input logic       iv,
    input logic       merr,
    input logic [3:0] ic
  );
    if (!iv)             return SINS;
    else if (merr)       return SADR;
    else if (ic == IHALT) return SHLT;
    else                 return SAOK;
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Register storage: two async read ports, two write ports.
// When both writes target one register the M port wins.
module regfile_2r2w
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_e_i,
  input  logic [3:0]        waddr_e_i,
  input  logic [DATA_W-1:0] wdata_e_i,
  input  logic              we_m_i,
  input  logic [3:0]        waddr_m_i,
  input  logic [DATA_W-1:0] wdata_m_i,
  input  logic [3:0]        raddr_a_i,
  input  logic [3:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic ok_e, ok_m, ok_a, ok_b;

  assign ok_e = we_e_i && (waddr_e_i != RNONE)
             && (int'(waddr_e_i) < NUM_REGS);
  assign ok_m = we_m_i && (waddr_m_i != RNONE)
             && (int'(waddr_m_i) < NUM_REGS);
  assign ok_a = (raddr_a_i != RNONE)
             && (int'(raddr_a_i) < NUM_REGS);
  assign ok_b = (raddr_b_i != RNONE)
             && (int'(raddr_b_i) < NUM_REGS);

  // Storage update; M write is last so it wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else begin
      if (ok_e) regs_q[waddr_e_i] <= wdata_e_i;
      if (ok_m) regs_q[waddr_m_i] <= wdata_m_i;
    end
  end

  assign rdata_a_o = ok_a ? regs_q[raddr_a_i] : '0;
  assign rdata_b_o = ok_b ? regs_q[raddr_b_i] : '0;

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: dst decode, status, retire count.
// Architectural state commits on the rising clock edge.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              instr_valid,
  input  logic              mem_error,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA_rd,
  output logic [DATA_W-1:0] valB_rd,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  wb_state_e        state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] dst_e, dst_m;
  logic [2:0] istat;
  logic       commit, ok, we;

  // Destination register decode for E and M ports
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ: dst_e = cnd ? rB : RNONE;
      IIRMOVQ: dst_e = rB;
      IOPQ:    dst_e = rB;
      IMRMOVQ: dst_m = rA;
      ICALL:   dst_e = RRSP;
      IRET:    dst_e = RRSP;
      IPUSHQ:  dst_e = RRSP;
      IPOPQ: begin
        dst_e = RRSP;
        dst_m = rA;
      end
      IHALT, INOP, IRMMOVQ, IJXX:
        dst_e = RNONE;
      default: dst_e = RNONE;
    endcase
  end

  assign istat  = instr_stat(instr_valid, mem_error, icode);
  assign commit = wb_en && (state_q == ST_RUN);
  assign ok     = (istat == SAOK);

  // State, status and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stat_q    <= SAOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  // Next state: a non-AOK commit stops the machine for good
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    if (commit) begin
      if (ok) begin
        retired_d = retired_q + CNT_W'(1);
      end else begin
        state_d = ST_STOP;
        stat_d  = istat;
      end
    end
  end

  // Outputs: write enables and visible status
  always_comb begin
    we      = commit && ok;
    halted  = (state_q == ST_STOP);
    stat    = stat_q;
    retired = retired_q;
  end

  regfile_2r2w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_e_i    (we),
    .waddr_e_i (dst_e),
    .wdata_e_i (valE),
    .we_m_i    (we),
    .waddr_m_i (dst_m),
    .wdata_m_i (valM),
    .raddr_a_i (srcA),
    .raddr_b_i (srcB),
    .rdata_a_o (valA_rd),
    .rdata_b_o (valB_rd)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: vector table, corner
// sequences and randomized run against a reference model.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  rA, rB;
  logic [63:0] valE, valM;
  logic        instr_valid, mem_error;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA_rd, valB_rd;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] retired;

  int checks = 0;
  int errors = 0;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .icode(icode),
    .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
    .instr_valid(instr_valid), .mem_error(mem_error),
    .srcA(srcA), .srcB(srcB), .valA_rd(valA_rd),
    .valB_rd(valB_rd), .stat(stat), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [63:0] mregs [16];
  logic [2:0]  mstat;
  logic [63:0] mret;

  typedef struct {
    logic        wb;
    logic [3:0]  ic;
    logic        c;
    logic [3:0]  ra, rb;
    logic [63:0] ve, vm;
    logic        iv, me;
    logic [3:0]  sa, sb;
    logic [63:0] ea, eb;
    logic [2:0]  es;
    logic [63:0] er;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(
    logic wb, logic [3:0] ic, logic c, logic [3:0] ra,
    logic [3:0] rb, logic [63:0] ve, logic [63:0] vm,
    logic iv, logic me, logic [3:0] sa, logic [3:0] sb,
    logic [63:0] ea, logic [63:0] eb, logic [2:0] es,
    logic [63:0] er);
    vec_t v;
    v.wb = wb; v.ic = ic; v.c = c; v.ra = ra; v.rb = rb;
    v.ve = ve; v.vm = vm; v.iv = iv; v.me = me;
    v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
    v.es = es; v.er = er;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mstat = 3'd1;
    mret  = '0;
  endtask

  // Architectural rules expressed directly
  task automatic model_commit();
    logic [2:0] s;
    int e, m;
    if (!wb_en || mstat != 3'd1) return;
    if (!instr_valid)    s = 3'd4;
    else if (mem_error)  s = 3'd3;
    else if (icode == 0) s = 3'd2;
    else                 s = 3'd1;
    if (s != 3'd1) begin
      mstat = s;
      return;
    end
    e = 15;
    m = 15;
    if ((icode == 2 && cnd) || icode == 3 || icode == 6)
      e = int'(rB);
    else if (icode >= 8 && icode <= 11)
      e = 4;
    if (icode == 5 || icode == 11)
      m = int'(rA);
    if (e != 15) mregs[e] = valE;
    if (m != 15) mregs[m] = valM;
    mret = mret + 64'd1;
  endtask

  function automatic logic [63:0] mread(logic [3:0] a);
    return (a == 4'hF) ? 64'd0 : mregs[a];
  endfunction

  task automatic idle();
    wb_en = 0; icode = 4'h1; cnd = 0; rA = 4'hF; rB = 4'hF;
    valE = '0; valM = '0; instr_valid = 1; mem_error = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic issue(logic w, logic [3:0] ic, logic c,
    logic [3:0] a, logic [3:0] b, logic [63:0] e,
    logic [63:0] m, logic iv, logic me);
    wb_en = w; icode = ic; cnd = c; rA = a; rB = b;
    valE = e; valM = m; instr_valid = iv; mem_error = me;
    @(posedge clk);
    #1 idle();
  endtask

  initial begin
    srcA = 4'hF;
    srcB = 4'hF;
    do_reset();

    // reset state
    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i);
      #1 chk($sformatf("rst_r%0d", i), valA_rd, 64'd0);
    end
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retired", retired, 64'd0);

    vecs[0] = mk(1,4'h3,0,4'hF,4'h2,64'h10,0,1,0,
                 4'h2,4'hF,64'h10,0,3'd1,64'd1);
    vecs[1] = mk(0,4'h3,0,4'hF,4'h6,64'h99,0,1,0,
                 4'h6,4'h2,0,64'h10,3'd1,64'd1);
    vecs[2] = mk(1,4'h2,0,4'h2,4'h3,64'h55,0,1,0,
                 4'h3,4'h2,0,64'h10,3'd1,64'd2);
    vecs[3] = mk(1,4'h2,1,4'h2,4'h3,64'h55,0,1,0,
                 4'h3,4'h2,64'h55,64'h10,3'd1,64'd3);
    vecs[4] = mk(1,4'hB,0,4'h4,4'hF,64'h108,64'h77,1,0,
                 4'h4,4'h3,64'h77,64'h55,3'd1,64'd4);
    vecs[5] = mk(1,4'h5,0,4'h5,4'hF,0,64'hABCD,1,0,
                 4'h5,4'h4,64'hABCD,64'h77,3'd1,64'd5);
    vecs[6] = mk(1,4'h8,0,4'hF,4'hF,64'h100,0,1,1,
                 4'h4,4'h5,64'h77,64'hABCD,3'd3,64'd5);
    vecs[7] = mk(1,4'h6,0,4'h2,4'h1,64'h9,0,1,0,
                 4'h1,4'h4,0,64'h77,3'd3,64'd5);

    for (int k = 0; k < 8; k++) begin
      issue(vecs[k].wb, vecs[k].ic, vecs[k].c, vecs[k].ra,
            vecs[k].rb, vecs[k].ve, vecs[k].vm,
            vecs[k].iv, vecs[k].me);
      srcA = vecs[k].sa;
      srcB = vecs[k].sb;
      #1;
      chk($sformatf("v%0d_a", k), valA_rd, vecs[k].ea);
      chk($sformatf("v%0d_b", k), valB_rd, vecs[k].eb);
      chk($sformatf("v%0d_stat", k), 64'(stat),
          64'(vecs[k].es));
      chk($sformatf("v%0d_halt", k), 64'(halted),
          64'(vecs[k].es != 3'd1));
      chk($sformatf("v%0d_ret", k), retired, vecs[k].er);
    end

    // halt then bad instruction: status sticks at HLT
    do_reset();
    issue(1, 4'h0, 0, 4'hF, 4'hF, 0, 0, 1, 0);
    chk("hlt_stat", 64'(stat), 64'd2);
    issue(1, 4'h1, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    chk("hlt_sticky", 64'(stat), 64'd2);
    chk("hlt_ret", retired, 64'd0);

    // bad instruction first
    do_reset();
    issue(1, 4'h1, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    chk("ins_stat", 64'(stat), 64'd4);
    chk("ins_halted", 64'(halted), 64'd1);

    // async reset between edges
    do_reset();
    issue(1, 4'h3, 0, 4'hF, 4'h7, 64'h1234, 0, 1, 0);
    issue(1, 4'hA, 0, 4'h1, 4'hF, 64'hF0, 0, 1, 0);
    srcA = 4'h7;
    srcB = 4'h4;
    #1;
    chk("pre_rst_a", valA_rd, 64'h1234);
    chk("pre_rst_ret", retired, 64'd2);
    wb_en = 1; icode = 4'h3; rB = 4'h7; valE = 64'hDEAD;
    #1 rst_n = 0;
    #1;
    chk("arst_a", valA_rd, 64'd0);
    chk("arst_b", valB_rd, 64'd0);
    chk("arst_stat", 64'(stat), 64'd1);
    chk("arst_ret", retired, 64'd0);
    @(posedge clk);
    #1;
    chk("arst_nowrite", valA_rd, 64'd0);
    rst_n = 1;
    idle();
    model_reset();

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0] a, b;
      if (mstat != 3'd1 && $urandom_range(0, 3) == 0)
        do_reset();
      wb_en = ($urandom_range(0, 3) != 0);
      icode = 4'($urandom_range(0, 11));
      if (icode == 0 && $urandom_range(0, 3) != 0)
        icode = 4'h6;
      cnd = 1'($urandom_range(0, 1));
      rA = 4'($urandom_range(0, 15));
      rB = 4'($urandom_range(0, 15));
      valE = {$urandom, $urandom};
      valM = {$urandom, $urandom};
      instr_valid = ($urandom_range(0, 39) != 0);
      mem_error = ($urandom_range(0, 39) == 0);
      model_commit();
      @(posedge clk);
      #1 idle();
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      srcA = a;
      srcB = b;
      #1;
      chk("rnd_a", valA_rd, mread(a));
      chk("rnd_b", valB_rd, mread(b));
      chk("rnd_stat", 64'(stat), 64'(mstat));
      chk("rnd_ret", retired, mret);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
